// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch unit and
//            the processor decode stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_e;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : ROM address/data bus plus the instruction valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;

    // Fetch-unit side
    modport master (
        output rom_addr,
        output instr,
        output instr_valid,
        input  rom_q,
        input  instr_ready
    );

    // ROM / processor side
    modport slave (
        input  rom_addr,
        input  instr,
        input  instr_valid,
        output rom_q,
        output instr_ready
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit_step_edge_det.sv
// ============================================================================
// Module   : step_edge_det
// Brief    : Registered rising-edge detector with asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_edge_det (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic d,
    output logic      rise
);
    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;
endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC owner and ROM-latency absorber feeding the processor through a
//            valid/ready handshake. Optional breakpoint: FETCH_BKPT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              run,
    input  wire logic              step,
`ifdef FETCH_BKPT_EN
    input  wire logic              bkpt_en,
    input  wire logic [ADDR_W-1:0] bkpt_addr,
`endif
    instr_fetch_unit_if.master     bus,
    output logic [ADDR_W-1:0]      pc,
    output logic [CNT_W-1:0]       fetch_count,
    output logic                   halted
);
    localparam logic [1:0]        LAT_INIT = 2'(ROM_LAT);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    fetch_state_e      state_q,  state_d;
    logic [ADDR_W-1:0] pc_q,     pc_d;
    logic [DATA_W-1:0] instr_q,  instr_d;
    logic              valid_q,  valid_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [1:0]        lat_q,    lat_d;
    logic              step_rise;
    logic [ADDR_W-1:0] pc_inc;
    logic              bkpt_cur;
    logic              bkpt_next;
    logic              single_q, single_d;
`ifdef FETCH_BKPT_EN
    logic              halted_q, halted_d;
`endif

    step_edge_det u_step_edge_det (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (step),
        .rise    (step_rise)
    );

    assign pc_inc = pc_q + PC_ONE;

`ifdef FETCH_BKPT_EN
    assign bkpt_cur  = bkpt_en && (pc_q   == bkpt_addr);
    assign bkpt_next = bkpt_en && (pc_inc == bkpt_addr);
`else
    assign bkpt_cur  = 1'b0;
    assign bkpt_next = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        count_d  = count_q;
        lat_d    = lat_q;
        single_d = single_q;
`ifdef FETCH_BKPT_EN
        halted_d = halted_q;
`endif
        case (state_q)
            IDLE: begin
                // run takes priority; a coincident step edge is simply consumed
                if (run) begin
                    if (bkpt_cur) begin
                        state_d = HALT;
`ifdef FETCH_BKPT_EN
                        halted_d = 1'b1;
`endif
                    end else begin
                        state_d = WAIT;
                        lat_d   = LAT_INIT;
                    end
                end else if (step_rise) begin
                    state_d = WAIT;
                    lat_d   = LAT_INIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - 2'd1;
                if (lat_q == 2'd1) begin
                    instr_d = bus.rom_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    pc_d     = pc_inc;
                    valid_d  = 1'b0;
                    single_d = 1'b0;
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_ONE;
                    end
                    // A fetch stepped out of HALT always lands in IDLE
                    if (run && !single_q) begin
                        if (bkpt_next) begin
                            state_d = HALT;
`ifdef FETCH_BKPT_EN
                            halted_d = 1'b1;
`endif
                        end else begin
                            state_d = WAIT;
                            lat_d   = LAT_INIT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
`ifdef FETCH_BKPT_EN
                if (step_rise) begin
                    state_d  = WAIT;
                    lat_d    = LAT_INIT;
                    halted_d = 1'b0;
                    single_d = 1'b1;
                end else if (!run) begin
                    state_d  = IDLE;
                    halted_d = 1'b0;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            lat_q    <= '0;
            single_q <= 1'b0;
`ifdef FETCH_BKPT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            lat_q    <= lat_d;
            single_q <= single_d;
`ifdef FETCH_BKPT_EN
            halted_q <= halted_d;
`endif
        end
    end

    // ROM samples the pc that will hold after this edge
    assign bus.rom_addr    = (state_q == HOLD && valid_q && bus.instr_ready) ? pc_inc : pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign pc              = pc_q;
    assign fetch_count     = count_q;
`ifdef FETCH_BKPT_EN
    assign halted          = halted_q;
`else
    assign halted          = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench for instr_fetch_unit (ROM_LAT=1 and ROM_LAT=3
//            instances). Breakpoint sequence runs when FETCH_BKPT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        run, run3, step;
    logic [4:0]  pc1, pc3;
    logic [15:0] cnt1, cnt3;
    logic        halted1, halted3;
`ifdef FETCH_BKPT_EN
    logic        bkpt_en;
    logic [4:0]  bkpt_addr;
`endif

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit_if #(.ADDR_W(5), .DATA_W(8)) bus1 ();
    instr_fetch_unit_if #(.ADDR_W(5), .DATA_W(8)) bus3 ();

    instr_fetch_unit #(.ADDR_W(5), .DATA_W(8), .ROM_LAT(1), .CNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .step        (step),
`ifdef FETCH_BKPT_EN
        .bkpt_en     (bkpt_en),
        .bkpt_addr   (bkpt_addr),
`endif
        .bus         (bus1),
        .pc          (pc1),
        .fetch_count (cnt1),
        .halted      (halted1)
    );

    instr_fetch_unit #(.ADDR_W(5), .DATA_W(8), .ROM_LAT(3), .CNT_W(16)) dut3 (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run3),
        .step        (1'b0),
`ifdef FETCH_BKPT_EN
        .bkpt_en     (1'b0),
        .bkpt_addr   (5'd0),
`endif
        .bus         (bus3),
        .pc          (pc3),
        .fetch_count (cnt3),
        .halted      (halted3)
    );

    function automatic logic [7:0] rom_val(input logic [4:0] a);
        case (a)
            5'd0:    rom_val = 8'h41;
            5'd1:    rom_val = 8'h08;
            5'd2:    rom_val = 8'h81;
            default: rom_val = {3'b101, a};
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM models: one and three edges of read latency
    logic [7:0] p3 [2];
    always_ff @(posedge clk) begin
        bus1.rom_q <= rom_val(bus1.rom_addr);
        p3[0]      <= rom_val(bus3.rom_addr);
        p3[1]      <= p3[0];
        bus3.rom_q <= p3[1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0;
        run3 = 1'b0;
        step = 1'b0;
        bus1.instr_ready = 1'b0;
        bus3.instr_ready = 1'b0;
`ifdef FETCH_BKPT_EN
        bkpt_en = 1'b0;
        bkpt_addr = 5'd0;
`endif
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        run;
        logic        ready;
        logic        exp_valid;
        logic [7:0]  exp_instr;
        logic [4:0]  exp_pc;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Run-mode stream, stall, then run dropped while a fetch is in flight
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h41, 5'd0, 16'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h41, 5'd1, 16'd1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h08, 5'd1, 16'd1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h08, 5'd2, 16'd2};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h81, 5'd2, 16'd2};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h81, 5'd3, 16'd3};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'hA3, 5'd3, 16'd3};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'hA3, 5'd3, 16'd3};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'hA3, 5'd3, 16'd3};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'hA3, 5'd4, 16'd4};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 8'hA4, 5'd4, 16'd4};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'hA4, 5'd5, 16'd5};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'hA4, 5'd5, 16'd5};

        reset_n = 1'b0;
        run = 1'b0;
        run3 = 1'b0;
        step = 1'b0;
        bus1.instr_ready = 1'b0;
        bus3.instr_ready = 1'b0;
`ifdef FETCH_BKPT_EN
        bkpt_en = 1'b0;
        bkpt_addr = 5'd0;
`endif
        #2;
        check("reset_valid", 32'(bus1.instr_valid), 32'd0);
        check("reset_instr", 32'(bus1.instr), 32'd0);
        check("reset_pc", 32'(pc1), 32'd0);
        check("reset_count", 32'(cnt1), 32'd0);
        check("reset_halted", 32'(halted1), 32'd0);
        check("reset_rom_addr", 32'(bus1.rom_addr), 32'd0);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            run = vecs[i].run;
            bus1.instr_ready = vecs[i].ready;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(bus1.instr_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_instr", i), 32'(bus1.instr), 32'(vecs[i].exp_instr));
            check($sformatf("vec%0d_pc", i), 32'(pc1), 32'(vecs[i].exp_pc));
            check($sformatf("vec%0d_count", i), 32'(cnt1), 32'(vecs[i].exp_cnt));
        end

        // Single-step: each rising edge yields exactly one word even when held
        do_reset();
        bus1.instr_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            repeat (10) tick();
            check($sformatf("step%0d_count", k), 32'(cnt1), 32'(k));
            check($sformatf("step%0d_instr", k), 32'(bus1.instr), 32'(rom_val(5'(k - 1))));
            step = 1'b0;
            repeat (2) tick();
        end
        check("step_pc", 32'(pc1), 32'd3);

        // Stall on first word for 7 cycles
        do_reset();
        run = 1'b1;
        bus1.instr_ready = 1'b0;
        begin
            int n = 0;
            while (!bus1.instr_valid && n < 20) begin
                tick();
                n++;
            end
        end
        check("stall_valid_rise", 32'(bus1.instr_valid), 32'd1);
        for (int c = 0; c < 7; c++) begin
            tick();
            check($sformatf("stall_c%0d", c), {23'd0, bus1.instr_valid, bus1.instr}, {23'd0, 1'b1, 8'h41});
            check($sformatf("stall_pc_c%0d", c), 32'(pc1), 32'd0);
        end
        bus1.instr_ready = 1'b1;
        tick();
        check("stall_release_pc", 32'(pc1), 32'd1);
        check("stall_release_count", 32'(cnt1), 32'd1);

        // PC wrap 31 -> 0
        do_reset();
        run = 1'b1;
        bus1.instr_ready = 1'b1;
        begin
            int n = 0;
            while (!(bus1.instr_valid && pc1 == 5'd31) && n < 200) begin
                tick();
                n++;
            end
        end
        check("wrap_reach_pc31", {31'd0, bus1.instr_valid && pc1 == 5'd31}, 32'd1);
        check("wrap_instr31", 32'(bus1.instr), 32'h000000BF);
        check("wrap_rom_addr", 32'(bus1.rom_addr), 32'd0);
        tick();
        check("wrap_pc", 32'(pc1), 32'd0);
        check("wrap_count", 32'(cnt1), 32'd32);
        tick();
        check("wrap_continue", {23'd0, bus1.instr_valid, bus1.instr}, {23'd0, 1'b1, 8'h41});

        // Reset mid-WAIT with ROM_LAT=3
        do_reset();
        run3 = 1'b1;
        bus3.instr_ready = 1'b1;
        repeat (3) tick();
        check("lat3_no_early_valid", 32'(bus3.instr_valid), 32'd0);
        tick();
        check("lat3_first_word", {23'd0, bus3.instr_valid, bus3.instr}, {23'd0, 1'b1, 8'h41});
        tick();
        check("lat3_pc_after_accept", 32'(pc3), 32'd1);
        tick();
        reset_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(bus3.instr_valid), 32'd0);
        check("async_reset_pc", 32'(pc3), 32'd0);
        check("async_reset_count", 32'(cnt3), 32'd0);
        tick();
        reset_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("post_reset_e%0d_valid", c), 32'(bus3.instr_valid), 32'd0);
        end
        tick();
        check("post_reset_word", {18'd0, bus3.instr_valid, bus3.instr, pc3}, {18'd0, 1'b1, 8'h41, 5'd0});

`ifdef FETCH_BKPT_EN
        // Breakpoint at 4, then step past it
        do_reset();
        bkpt_en = 1'b1;
        bkpt_addr = 5'd4;
        run = 1'b1;
        bus1.instr_ready = 1'b1;
        begin
            int n = 0;
            while (!halted1 && n < 60) begin
                tick();
                n++;
            end
        end
        check("bkpt_halted", 32'(halted1), 32'd1);
        check("bkpt_pc", 32'(pc1), 32'd4);
        check("bkpt_count", 32'(cnt1), 32'd4);
        repeat (3) tick();
        check("bkpt_parked", {30'd0, halted1, bus1.instr_valid}, {30'd0, 1'b1, 1'b0});
        step = 1'b1;
        tick();
        check("bkpt_step_unhalt", 32'(halted1), 32'd0);
        begin
            int n = 0;
            while (!bus1.instr_valid && n < 10) begin
                tick();
                n++;
            end
        end
        check("bkpt_step_word", {23'd0, bus1.instr_valid, bus1.instr}, {23'd0, 1'b1, 8'hA4});
        tick();
        check("bkpt_step_accept", {16'd0, 6'd0, cnt1[4:0], pc1}, {16'd0, 6'd0, 5'd5, 5'd5});
        tick();
        check("bkpt_idle_gap", 32'(bus1.instr_valid), 32'd0);
        tick();
        check("bkpt_resume", {23'd0, bus1.instr_valid, bus1.instr}, {23'd0, 1'b1, 8'hA5});
        step = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
